// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding controller with a private destination scoreboard.
// Optional HAZARD_STATS_EN macro adds saturating stall/flush event counters.
module hazard_fwd_unit #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wen,
  input  logic [ADDR_W-1:0] id_waddr,
  input  logic              id_is_load,
  input  logic              id_redirect,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              stall,
  output logic              if_en,
  output logic              id_en,
  output logic              id_rst,
  output logic              exe_rst
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             not_ready;
  } fwd_t;

  // Scoreboard: index 0 = EXE, growing towards WB.
  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  ld_q;
  logic [ADDR_W-1:0] waddr_q [DEPTH];
  logic [DEPTH-1:0]  rdy;

  fwd_t fwd_a;
  fwd_t fwd_b;

  // Readiness depends only on where a load currently sits, so it is derived
  // from the index instead of being stored and recomputed on every shift.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      rdy[k] = ~ld_q[k] | (k >= LOAD_READY);
    end
  end

  function automatic fwd_t lookup(input logic used, input logic [ADDR_W-1:0] addr);
    fwd_t r;
    r = '0;
    // Scanning oldest to youngest lets the youngest match overwrite the rest.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used && addr != '0 && v_q[k] && waddr_q[k] == addr) begin
        r.sel       = rdy[k] ? SEL_W'(k + 1) : '0;
        r.not_ready = ~rdy[k];
      end
    end
    return r;
  endfunction

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    fwd_a     = lookup(id_rs_used, id_rs);
    fwd_b     = lookup(id_rt_used, id_rt);
    fwd_a_sel = fwd_a.sel;
    fwd_b_sel = fwd_b.sel;
    stall     = id_valid & (fwd_a.not_ready | fwd_b.not_ready);
    if_en     = ~hold & ~stall;
    id_en     = ~hold & ~stall;
    exe_rst   = ~hold & stall;
    // A stalled branch has unresolved operands, so its redirect is not trusted.
    id_rst    = ~hold & ~stall & id_redirect;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the shift order inside the loop is irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        v_q[k] <= v_q[k-1];
      end
      v_q[0] <= id_valid & id_wen & ~stall;
    end
  end

  // NOTE: only the valid bits need reset; address and load flags are ignored
  // while their valid bit is clear, so they stay plain unreset flops.
  always_ff @(posedge clk) begin
    if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        waddr_q[k] <= waddr_q[k-1];
        ld_q[k]    <= ld_q[k-1];
      end
      waddr_q[0] <= id_waddr;
      ld_q[0]    <= id_is_load;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (exe_rst && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (id_rst && flush_cnt != '1)  flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit at default parameters; stats checks run
// only when HAZARD_STATS_EN is defined for both files.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_waddr;
  logic       id_rs_used, id_rt_used, id_wen, id_is_load, id_redirect;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, if_en, id_en, id_rst, exe_rst;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  hazard_fwd_unit dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wen(id_wen), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .id_redirect(id_redirect), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .if_en(if_en), .id_en(id_en), .id_rst(id_rst), .exe_rst(exe_rst)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive an ID instruction: valid, rs/used, rt/used, writer dest (wen), load, redirect.
  task automatic set_id(input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic wen,
                        input logic [4:0] wa, input logic ld, input logic redir);
    id_valid = v;  id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_wen = wen;  id_waddr = wa; id_is_load = ld; id_redirect = redir;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    idle();
    #2;
    check("rst_stall", stall, 0);
    check("rst_sel_a", fwd_a_sel, 0);
    check("rst_sel_b", fwd_b_sel, 0);
    check("rst_if_en", if_en, 1);
    check("rst_id_en", id_en, 1);
    check("rst_strobes", {id_rst, exe_rst}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // add r3 ; sub r4,r3,r1
    set_id(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0);
    step();
    set_id(1, 5'd3, 1, 5'd1, 1, 1, 5'd4, 0, 0);
    check("alu_fwd_a", fwd_a_sel, 1);
    check("alu_fwd_b", fwd_b_sel, 0);
    check("alu_stall", stall, 0);
    check("alu_exe_rst", exe_rst, 0);
    drain();

    // lw r5 ; add r6,r5,r5
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 1, 0);
    step();
    set_id(0, 5'd5, 1, 5'd5, 1, 0, 5'd0, 0, 0);
    check("lu_invalid_nostall", stall, 0);
    set_id(1, 5'd5, 1, 5'd5, 1, 1, 5'd6, 0, 0);
    check("lu_c1_stall", stall, 1);
    check("lu_c1_exe_rst", exe_rst, 1);
    check("lu_c1_if_en", if_en, 0);
    check("lu_c1_id_en", id_en, 0);
    check("lu_c1_sel", {fwd_a_sel, fwd_b_sel}, 0);
    step();
    check("lu_c2_stall", stall, 0);
    check("lu_c2_fwd_a", fwd_a_sel, 2);
    check("lu_c2_fwd_b", fwd_b_sel, 2);
    check("lu_c2_exe_rst", exe_rst, 0);
    check("lu_c2_if_en", if_en, 1);
    drain();

    // r0 writers (alu in MEM, load in EXE) never forward or stall
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0);
    step();
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 1, 0);
    step();
    set_id(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0);
    check("r0_fwd_a", fwd_a_sel, 0);
    check("r0_fwd_b", fwd_b_sel, 0);
    check("r0_stall", stall, 0);
    drain();

    // r7 in EXE and WB, r8 in MEM
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 0);
    step();
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd8, 0, 0);
    step();
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 0);
    step();
    set_id(1, 5'd8, 1, 5'd7, 1, 0, 5'd0, 0, 0);
    check("young_fwd_b", fwd_b_sel, 1);
    check("mem_fwd_a", fwd_a_sel, 2);
    set_id(1, 5'd8, 1, 5'd7, 0, 0, 5'd0, 0, 0);
    check("unused_rt", fwd_b_sel, 0);
    idle();
    step();
    set_id(1, 5'd8, 1, 5'd7, 1, 0, 5'd0, 0, 0);
    check("shift_fwd_b", fwd_b_sel, 2);
    check("wb_fwd_a", fwd_a_sel, 3);
    idle();
    step();
    set_id(1, 5'd8, 1, 5'd7, 1, 0, 5'd0, 0, 0);
    check("discard_fwd_a", fwd_a_sel, 0);
    check("wb_fwd_b", fwd_b_sel, 3);
    drain();

    // beq on a load result with redirect
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 1, 0);
    step();
    set_id(1, 5'd9, 1, 5'd0, 1, 0, 5'd0, 0, 1);
    check("br_c1_stall", stall, 1);
    check("br_c1_id_rst", id_rst, 0);
    step();
    check("br_c2_stall", stall, 0);
    check("br_c2_id_rst", id_rst, 1);
    check("br_c2_fwd_a", fwd_a_sel, 2);
    drain();

    // hold freezes a load in EXE, then async reset mid-stall
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd10, 1, 0);
    step();
    hold = 1'b1;
    set_id(1, 5'd10, 1, 5'd0, 0, 0, 5'd0, 0, 1);
    check("hold_stall", stall, 1);
    check("hold_strobes", {if_en, id_en, id_rst, exe_rst}, 0);
    repeat (3) step();
    check("hold_frozen_stall", stall, 1);
    hold = 1'b0;
    #1;
    check("unhold_exe_rst", exe_rst, 1);
    check("unhold_stall", stall, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_stall", stall, 0);
    check("async_rst_if_en", if_en, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_stall", stall, 0);
    check("post_rst_sel", fwd_a_sel, 0);
    idle();
    step();

`ifdef HAZARD_STATS_EN
    check("cnt_rst_stall", stall_cnt, 0);
    check("cnt_rst_flush", flush_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd11, 1, 0);
      step();
      set_id(1, 5'd11, 1, 5'd0, 0, 0, 5'd0, 0, 0);
      step();
      step();
      drain();
    end
    for (int i = 0; i < 2; i++) begin
      set_id(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1);
      step();
      idle();
      step();
    end
    check("cnt_stall", stall_cnt, 4);
    check("cnt_flush", flush_cnt, 2);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd12, 1, 0);
    step();
    set_id(1, 5'd12, 1, 5'd0, 0, 0, 5'd0, 0, 0);
    step();
    check("cnt_saturate", stall_cnt, 32'hFFFF_FFFF);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
